// File: rtl/hour24_tz_counter.sv
// Hour stage of the clock chain: UTC hour register, handshaked time-zone offset,
// and a registered local-hour / 12-24h BCD display view.
module hour24_tz_counter #(
    parameter int TZ_MIN = -12,
    parameter int TZ_MAX = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       min_cycle,
    input  logic       set_valid,
    input  logic [4:0] set_hour,
    input  logic       tz_valid,
    input  logic [4:0] tz_offset,
    output logic       tz_ready,
    output logic       tz_err,
    output logic [4:0] tz_active,
    input  logic       mode12,
    output logic [4:0] utc_hour,
    output logic [4:0] local_hour,
    output logic [1:0] day_adj,
    output logic [7:0] disp_bcd,
    output logic       pm,
    output logic       day_cycle
);

    localparam int unsigned HW = 5;
    localparam int unsigned SW = 7;
    localparam logic signed [SW-1:0] TZ_LO = SW'(TZ_MIN);
    localparam logic signed [SW-1:0] TZ_HI = SW'(TZ_MAX);
    localparam logic [HW-1:0] LAST_HOUR = HW'(23);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   capture;
    logic                   commit;
    logic                   reject;
    logic [HW-1:0]          pending;
    logic signed [SW-1:0]   pend_ext;
    logic                   in_range;
    logic [HW-1:0]          utc_next;
    logic signed [SW-1:0]   sum;
    logic [HW-1:0]          local_next;
    logic [1:0]             adj_next;
    logic [HW-1:0]          disp_val;
    logic [3:0]             tens;
    logic [3:0]             ones;

    assign pend_ext  = $signed({{(SW-HW){pending[HW-1]}}, pending});
    assign in_range  = (pend_ext >= TZ_LO) && (pend_ext <= TZ_HI);
    assign tz_ready  = (state == IDLE);
    assign day_cycle = min_cycle & ~set_valid & (utc_hour == LAST_HOUR);

    // Offset handshake: accept in IDLE, range-check the captured value in CHECK
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        commit     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (tz_valid) begin
                    capture    = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (in_range) begin
                    commit = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pending   <= '0;
            tz_active <= '0;
            tz_err    <= 1'b0;
        end else begin
            state  <= state_next;
            tz_err <= reject;
            if (capture) begin
                pending <= tz_offset;
            end
            if (commit) begin
                tz_active <= pending;
            end
        end
    end

    // An out-of-range load request also swallows that cycle's minute pulse
    always_comb begin
        utc_next = utc_hour;
        if (set_valid) begin
            if (set_hour <= LAST_HOUR) begin
                utc_next = set_hour;
            end
        end else if (min_cycle) begin
            utc_next = (utc_hour == LAST_HOUR) ? '0 : utc_hour + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            utc_hour <= '0;
        end else begin
            utc_hour <= utc_next;
        end
    end

    // Local hour wraps into the previous/next day around the UTC hour
    always_comb begin
        sum        = $signed({{(SW-HW){1'b0}}, utc_hour})
                   + $signed({{(SW-HW){tz_active[HW-1]}}, tz_active});
        local_next = HW'(sum);
        adj_next   = 2'b00;
        if (sum < 0) begin
            local_next = HW'(sum + SW'(24));
            adj_next   = 2'b11;
        end else if (sum > SW'(23)) begin
            local_next = HW'(sum - SW'(24));
            adj_next   = 2'b01;
        end
    end

    always_comb begin
        disp_val = local_next;
        if (mode12) begin
            if (local_next == '0) begin
                disp_val = HW'(12);
            end else if (local_next >= HW'(13)) begin
                disp_val = local_next - HW'(12);
            end
        end
        tens = 4'd0;
        ones = 4'(disp_val);
        if (disp_val >= HW'(20)) begin
            tens = 4'd2;
            ones = 4'(disp_val - HW'(20));
        end else if (disp_val >= HW'(10)) begin
            tens = 4'd1;
            ones = 4'(disp_val - HW'(10));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            local_hour <= '0;
            day_adj    <= 2'b00;
            disp_bcd   <= 8'h00;
            pm         <= 1'b0;
        end else begin
            local_hour <= local_next;
            day_adj    <= adj_next;
            disp_bcd   <= {tens, ones};
            pm         <= (local_next >= HW'(12));
        end
    end

endmodule

// File: tb/tb_hour24_tz_counter.sv
// Bench for hour24_tz_counter: directed scenarios plus random traffic, all checked
// against an integer-arithmetic model of hour, offset and local-time rules.
module tb_hour24_tz_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       min_cycle, set_valid, tz_valid, mode12;
    logic [4:0] set_hour, tz_offset;
    logic       tz_ready, tz_err, pm, day_cycle;
    logic [4:0] tz_active, utc_hour, local_hour;
    logic [1:0] day_adj;
    logic [7:0] disp_bcd;

    int checks = 0;
    int failures = 0;

    // Model state
    int  m_utc, m_tz, m_pend, m_local, m_adj, m_bcd;
    bit  m_busy, m_err, m_pm;

    hour24_tz_counter #(.TZ_MIN(-12), .TZ_MAX(14)) dut (
        .clk(clk), .reset(reset), .min_cycle(min_cycle), .set_valid(set_valid),
        .set_hour(set_hour), .tz_valid(tz_valid), .tz_offset(tz_offset),
        .tz_ready(tz_ready), .tz_err(tz_err), .tz_active(tz_active), .mode12(mode12),
        .utc_hour(utc_hour), .local_hour(local_hour), .day_adj(day_adj),
        .disp_bcd(disp_bcd), .pm(pm), .day_cycle(day_cycle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_utc = 0; m_tz = 0; m_pend = 0; m_local = 0; m_adj = 0; m_bcd = 0;
        m_busy = 0; m_err = 0; m_pm = 0;
    endtask

    task automatic check_regs();
        check("utc_hour", int'(utc_hour), m_utc);
        check("tz_active", int'($signed(tz_active)), m_tz);
        check("tz_err", int'(tz_err), int'(m_err));
        check("local_hour", int'(local_hour), m_local);
        check("day_adj", int'(day_adj), m_adj);
        check("disp_bcd", int'(disp_bcd), m_bcd);
        check("pm", int'(pm), int'(m_pm));
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model, check registers
    task automatic step(input bit mc, input bit sv, input int sh, input bit tv,
                        input int to, input bit m12);
        int s, lh, dv, n_utc;
        min_cycle = mc; set_valid = sv; set_hour = 5'(sh);
        tz_valid = tv; tz_offset = 5'(to); mode12 = m12;
        #1;
        check("day_cycle", int'(day_cycle), int'(mc && !sv && m_utc == 23));
        check("tz_ready", int'(tz_ready), int'(!m_busy));
        n_utc = m_utc;
        if (sv) begin
            if (sh <= 23) n_utc = sh;
        end else if (mc) begin
            n_utc = (m_utc + 1) % 24;
        end
        s  = m_utc + m_tz;
        lh = (s + 24) % 24;
        if (m12) dv = (lh == 0) ? 12 : (lh > 12 ? lh - 12 : lh);
        else     dv = lh;
        @(posedge clk);
        #1;
        m_local = lh;
        m_adj   = (s < 0) ? 3 : (s > 23 ? 1 : 0);
        m_pm    = (lh >= 12);
        m_bcd   = (dv / 10) * 16 + dv % 10;
        m_utc   = n_utc;
        m_err   = 0;
        if (m_busy) begin
            if (m_pend >= -12 && m_pend <= 14) m_tz = m_pend;
            else m_err = 1;
            m_busy = 0;
        end else if (tv) begin
            m_pend = int'($signed(5'(to)));
            m_busy = 1;
        end
        check_regs();
    endtask

    task automatic idle(input bit m12);
        step(0, 0, 0, 0, 0, m12);
    endtask

    task automatic set_tz(input int off);
        step(0, 0, 0, 1, off, 0);
        idle(0);
    endtask

    initial begin
        reset = 1'b0; min_cycle = 0; set_valid = 0; set_hour = 0;
        tz_valid = 0; tz_offset = 0; mode12 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_utc", int'(utc_hour), 0);
        check("rst_tz_ready", int'(tz_ready), 1);
        check("rst_disp", int'(disp_bcd), 8'h00);
        check_regs();
        @(negedge clk);
        reset = 1'b1;

        // Full day of minute-wrap pulses
        for (int i = 0; i < 24; i++) step(1, 0, 0, 0, 0, 0);
        check("wrap_utc", int'(utc_hour), 0);
        check("wrap_local", int'(local_hour), 23);
        idle(0);

        // Load overrides minute pulse; illegal load also blocks the pulse
        step(1, 1, 22, 0, 0, 0);
        check("load22", int'(utc_hour), 22);
        step(1, 1, 25, 0, 0, 0);
        check("load25_ignored", int'(utc_hour), 22);

        // Negative offset crosses into the previous day
        step(0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 1, 5'b11011, 0);
        check("ready_low", int'(tz_ready), 0);
        idle(0);
        check("tz_m5", int'(tz_active), 5'h1B);
        idle(0);
        check("local_m5", int'(local_hour), 22);
        check("adj_m5", int'(day_adj), 3);
        check("pm_m5", int'(pm), 1);

        // Maximum offset crosses into the next day; 15 is rejected
        step(0, 1, 20, 0, 0, 0);
        set_tz(14);
        idle(0);
        check("local_p14", int'(local_hour), 10);
        check("adj_p14", int'(day_adj), 1);
        step(0, 0, 0, 1, 15, 0);
        idle(0);
        check("err_pulse", int'(tz_err), 1);
        check("tz_keep14", int'(tz_active), 14);
        idle(0);
        check("err_clear", int'(tz_err), 0);
        set_tz(-13);
        check("tz_keep14b", int'(tz_active), 14);

        // 12-hour display at the midnight/noon boundaries
        set_tz(0);
        step(0, 1, 0, 0, 0, 1);  idle(1);
        check("disp_0", int'(disp_bcd), 8'h12);
        check("pm_0", int'(pm), 0);
        step(0, 1, 12, 0, 0, 1); idle(1);
        check("disp_12", int'(disp_bcd), 8'h12);
        check("pm_12", int'(pm), 1);
        step(0, 1, 13, 0, 0, 1); idle(1);
        check("disp_13", int'(disp_bcd), 8'h01);
        check("pm_13", int'(pm), 1);
        idle(0);
        check("disp_13_24h", int'(disp_bcd), 8'h13);

        // Reset while an offset is pending in CHECK
        step(0, 0, 0, 1, 3, 0);
        reset = 1'b0;
        #1;
        model_reset();
        check("rstchk_tz", int'(tz_active), 0);
        check("rstchk_err", int'(tz_err), 0);
        check("rstchk_local", int'(local_hour), 0);
        @(negedge clk);
        reset = 1'b1;
        idle(0);
        check("rstchk_ready", int'(tz_ready), 1);
        check("rstchk_tz2", int'(tz_active), 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(bit'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 31)),
                 $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 31)),
                 bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hour24_tz_counter.md
Name: hour24_tz_counter

Overview:
- Hour stage directly downstream of the minute counter; consumes its one-cycle minute-wrap pulse as the hour increment.
- Maintains the UTC hour (0-23) and a committed time-zone offset accepted over a valid/ready handshake.
- Produces the local hour with day-adjust flag, 12/24-hour BCD display value and PM flag.
- Emits a combinational day-wrap pulse for a downstream day counter.

Parameters:
TZ_MIN, -12, most negative legal offset (hours, signed)
TZ_MAX, 14, most positive legal offset (hours, signed)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
min_cycle  input  1  minute-wrap pulse from minute counter; sampled at rising edge as an hour increment
set_valid  input  1  load request for UTC hour
set_hour  input  5  UTC hour to load (0-23)
tz_valid  input  1  time-zone offset offered
tz_offset  input  5  signed two's-complement offset, hours
tz_ready  output  1  block can accept an offset
tz_err  output  1  one-cycle pulse: offered offset rejected
tz_active  output  5  committed signed offset
mode12  input  1  1 = 12-hour display, 0 = 24-hour
utc_hour  output  5  current UTC hour
local_hour  output  5  local hour 0-23
day_adj  output  2  local day relative to UTC: 2'b00 same, 2'b01 +1, 2'b11 -1
disp_bcd  output  8  display hour, [7:4] tens, [3:0] ones
pm  output  1  local_hour >= 12
day_cycle  output  1  combinational: UTC hour wraps this edge

Behaviour:
Reset (reset==0, asynchronous):
- utc_hour=0, tz_active=0, FSM=IDLE, tz_err=0, local_hour=0, day_adj=00, disp_bcd=8'h00, pm=0.
- Reset during CHECK drops the pending offset: no commit, no tz_err.

UTC hour register, per rising edge:
- set_valid=1 and set_hour<=23: utc_hour<=set_hour. Overrides min_cycle.
- set_valid=1 and set_hour>23: request ignored, and min_cycle is also ignored that cycle.
- Else, min_cycle=1: utc_hour<=(utc_hour==23)?0:utc_hour+1.
- Else: hold.

day_cycle:
- day_cycle = min_cycle & ~set_valid & (utc_hour==23). Purely combinational, no register.

Offset FSM, states IDLE and CHECK:
- IDLE: tz_ready=1. On tz_valid&tz_ready, capture tz_offset into a pending register; next state CHECK.
- CHECK: tz_ready=0; tz_valid is ignored. Next state is always IDLE.
  - If TZ_MIN <= pending <= TZ_MAX (signed compare): tz_active<=pending.
  - Otherwise: tz_active unchanged; tz_err=1 for exactly this one cycle (registered, visible the cycle after CHECK is entered).
- Timing: handshake at edge N; tz_active updated at edge N+1; tz_ready high again after edge N+1.

Local computation, registered, 1-cycle latency:
- sum = utc_hour + tz_active, signed 7-bit, range -12..37.
- sum<0: local_hour<=sum+24, day_adj<=11.
- sum>23: local_hour<=sum-24, day_adj<=01.
- Else: local_hour<=sum, day_adj<=00.
- pm<=(local value >= 12).
- Display value:
  - mode12=0: disp = local value.
  - mode12=1: local 0 -> 12; local 13-23 -> local-12; otherwise local.
- disp_bcd<={tens, ones} of the display value.
- All of these update on the edge after utc_hour, tz_active or mode12 change.

Test Plan:
- Reset release with mode12=0, 24 min_cycle pulses -> utc_hour steps 0..23..0; day_cycle high only during the pulse while utc_hour=23; local_hour follows one cycle later.
- set_valid=1, set_hour=22 together with min_cycle=1 -> utc_hour=22, day_cycle=0. Then set_hour=25 -> utc_hour unchanged.
- tz_offset=-5 (5'b11011) handshake with utc_hour=3 -> tz_ready low 1 cycle, tz_active=-5, then local_hour=22, day_adj=11, pm=1.
- tz_offset=+14 with utc_hour=20 -> local_hour=10, day_adj=01. Then tz_offset=15 -> tz_err pulse one cycle, tz_active stays 14.
- mode12=1 with local 0, 12, 13 -> disp_bcd 8'h12, 8'h12, 8'h01; pm 0, 1, 1.
- Assert reset during CHECK with tz_offset=+3 -> tz_active=0, tz_err=0, tz_ready=1 after release.
